// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Transmit half of the UART peripheral. Bytes pushed from the register decode
//   are buffered in a FIFO and serialised onto uart_TX as 8N1 frames, with a
//   programmable bit period.
//
// Ports
//   clock     single clock for all logic
//   resetn    asynchronous active-low reset
//   wr_valid  byte push request
//   wr_data   byte to transmit
//   wr_ready  FIFO can accept a byte
//   clk_div   bit period in clock cycles (0 behaves as 1), sampled at frame start
//   irq_en    enables tx_irq
//   tx_level  bytes currently held in the FIFO (0..FIFO_DEPTH)
//   tx_busy   serialiser is not idle
//   tx_irq    drain interrupt (level, registered)
//   uart_TX   serial line, idle high, driven from a register
//
// Serialiser states
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte in the FIFO
//   S_START | start bit (low) for one bit period
//   S_DATA  | eight data bits, LSB first, one bit period each
//   S_STOP  | stop bit (high); chains straight into S_START if more bytes wait

module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  input  logic                          irq_en,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          tx_busy,
  output logic                          tx_irq,
  output logic                          uart_TX
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          LEVEL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]          LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  assign wr_ready   = (count != LEVEL_FULL);
  assign push       = wr_valid && wr_ready;
  assign fifo_empty = (count == '0);
  assign fifo_head  = mem[rd_ptr];
  assign tx_level   = count;

  // Storage has no reset: contents are meaningless once the pointers clear.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + LEVEL_ONE;
        2'b01:   count <= count - LEVEL_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------- serialiser
  state_t               state;
  state_t               state_next;
  logic                 load;
  logic [DIV_WIDTH-1:0] period;
  logic [DIV_WIDTH-1:0] cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift;
  logic                 tc;
  logic                 tx_line_next;
  logic                 irq_next;
  logic [2:0]           bit_idx_next;
  logic [DIV_WIDTH-1:0] div_eff;

  assign div_eff = (clk_div == '0) ? DIV_ONE : clk_div;
  assign tc      = (cnt == period - DIV_ONE);
  assign tx_busy = (state != S_IDLE);

  // State register plus the registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      uart_TX <= 1'b1;
      tx_irq  <= 1'b0;
    end else begin
      state   <= state_next;
      uart_TX <= tx_line_next;
      tx_irq  <= irq_next;
    end
  end

  // Next-state logic; pop and load happen together whenever a frame begins.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (tc) state_next = S_DATA;
      end
      S_DATA: begin
        if (tc && (bit_cnt == 3'd7)) state_next = S_STOP;
      end
      S_STOP: begin
        if (tc) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            load       = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: the line value for the coming cycle is computed from the
  // next state so that uart_TX can be a plain register.
  always_comb begin
    bit_idx_next = 3'd0;
    if (state == S_DATA) begin
      bit_idx_next = tc ? (bit_cnt + 3'd1) : bit_cnt;
    end
    case (state_next)
      S_START: tx_line_next = 1'b0;
      S_DATA:  tx_line_next = shift[bit_idx_next];
      default: tx_line_next = 1'b1;
    endcase
    irq_next = irq_en && fifo_empty && (state == S_IDLE);
  end

  // Bit-period timer and data path. The period is captured only at frame
  // start, so a clk_div change never disturbs a frame already on the line.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      period  <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (load) begin
      shift   <= fifo_head;
      period  <= div_eff;
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (state != S_IDLE) begin
      if (tc) begin
        cnt <= '0;
        if (state == S_DATA) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        cnt <= cnt + DIV_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
//   Directed bench for uart_tx_engine. Accepted bytes go into a scoreboard
//   queue; a frame receiver samples uart_TX every cycle, rebuilds each byte and
//   compares it with the queue head.

module tb_uart_tx_engine;

  localparam int FIFO_DEPTH = 16;
  localparam int DIV_WIDTH  = 16;

  logic                 clock;
  logic                 resetn;
  logic                 wr_valid;
  logic [7:0]           wr_data;
  logic                 wr_ready;
  logic [DIV_WIDTH-1:0] clk_div;
  logic                 irq_en;
  logic [4:0]           tx_level;
  logic                 tx_busy;
  logic                 tx_irq;
  logic                 uart_TX;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_tx_engine #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clk_div  (clk_div),
    .irq_en   (irq_en),
    .tx_level (tx_level),
    .tx_busy  (tx_busy),
    .tx_irq   (tx_irq),
    .uart_TX  (uart_TX)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one push cycle (wr_valid left high), records the byte if accepted.
  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    if (wr_ready) exp_q.push_back(b);
    @(negedge clock);
  endtask

  // Waits up to max_wait cycles for a start bit, then samples 10*period cycles.
  task automatic recv_frame(input int period, input int max_wait);
    int         waited;
    int         glitch;
    logic [9:0] first;
    logic [8:0] expv;
    logic       s;
    waited = 0;
    glitch = 0;
    first  = '0;
    while (uart_TX !== 1'b0 && waited < max_wait) begin
      @(negedge clock);
      waited++;
    end
    check("frame_start", {31'd0, uart_TX}, 32'd0);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < period; c++) begin
        s = uart_TX;
        if (c == 0) first[b] = s;
        else if (s !== first[b]) glitch++;
        @(negedge clock);
      end
    end
    expv = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
    check("frame_data", {23'd0, 1'b0, first[8:1]}, {23'd0, expv});
    check("frame_stop", {31'd0, first[9]}, 32'd1);
    check("frame_bit_hold", glitch, 0);
  endtask

  initial begin
    int bad;
    resetn   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    clk_div  = 16'd4;
    irq_en   = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clock);
    check("rst_line",  {31'd0, uart_TX},  32'd1);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_level", {27'd0, tx_level}, 32'd0);
    check("rst_busy",  {31'd0, tx_busy},  32'd0);
    check("rst_irq",   {31'd0, tx_irq},   32'd0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (uart_TX !== 1'b1 || tx_busy !== 1'b0 || tx_irq !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single byte, with drain interrupt
    irq_en = 1'b1;
    repeat (2) @(negedge clock);
    check("irq_idle_on", {31'd0, tx_irq}, 32'd1);
    clk_div = 16'd4;
    push_byte(8'hA5);
    wr_valid = 1'b0;
    check("start_latency_line", {31'd0, uart_TX}, 32'd1);
    check("single_level", {27'd0, tx_level}, 32'd1);
    check("irq_hold_after_push", {31'd0, tx_irq}, 32'd1);
    @(negedge clock);
    check("single_busy", {31'd0, tx_busy}, 32'd1);
    check("irq_drop_after_push", {31'd0, tx_irq}, 32'd0);
    recv_frame(4, 0);
    check("single_idle_busy", {31'd0, tx_busy}, 32'd0);
    check("irq_not_yet", {31'd0, tx_irq}, 32'd0);
    @(negedge clock);
    check("irq_drain", {31'd0, tx_irq}, 32'd1);
    check("single_line_idle", {31'd0, uart_TX}, 32'd1);

    // Back-to-back frames
    clk_div = 16'd2;
    push_byte(8'h00);
    check("b2b_level_1", {27'd0, tx_level}, 32'd1);
    push_byte(8'hFF);
    wr_valid = 1'b0;
    check("b2b_level_2", {27'd0, tx_level}, 32'd1);
    recv_frame(2, 0);
    check("b2b_level_3", {27'd0, tx_level}, 32'd0);
    check("b2b_busy", {31'd0, tx_busy}, 32'd1);
    recv_frame(2, 0);
    check("b2b_done_busy", {31'd0, tx_busy}, 32'd0);

    // Full FIFO
    clk_div = 16'd100;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          push_byte(8'(i));
          if (i == 16) begin
            check("full_level", {27'd0, tx_level}, 32'd16);
            check("full_ready", {31'd0, wr_ready}, 32'd0);
          end
        end
        wr_valid = 1'b0;
        check("full_no_overflow", {27'd0, tx_level}, 32'd16);
      end
      begin
        recv_frame(100, 10);
        for (int k = 1; k < 17; k++) recv_frame(100, 0);
      end
    join
    check("full_drained_level", {27'd0, tx_level}, 32'd0);
    check("full_drained_busy", {31'd0, tx_busy}, 32'd0);

    // Divisor edges
    clk_div = 16'd0;
    push_byte(8'h3C);
    wr_valid = 1'b0;
    recv_frame(1, 3);
    clk_div = 16'd3;
    push_byte(8'h96);
    push_byte(8'h5A);
    wr_valid = 1'b0;
    fork
      begin
        recv_frame(3, 3);
        recv_frame(8, 0);
      end
      begin
        repeat (10) @(negedge clock);
        clk_div = 16'd8;
      end
    join

    // Reset during DATA bit 3
    clk_div = 16'd4;
    for (int i = 0; i < 5; i++) push_byte(8'h00);
    wr_valid = 1'b0;
    repeat (14) @(negedge clock);
    check("pre_reset_line", {31'd0, uart_TX}, 32'd0);
    check("pre_reset_level", {27'd0, tx_level}, 32'd4);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_line", {31'd0, uart_TX}, 32'd1);
    check("async_reset_level", {27'd0, tx_level}, 32'd0);
    check("async_reset_busy", {31'd0, tx_busy}, 32'd0);
    check("async_reset_ready", {31'd0, wr_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (uart_TX !== 1'b1 || tx_busy !== 1'b0 || tx_level !== 5'd0) bad++;
    end
    check("post_reset_quiet", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Transmit half of the UART peripheral at 0x60000000, downstream of the AXI4 slave register decode. Accepts bytes written to the TX data register through a valid/ready push port and buffers them in a FIFO. Serialises them onto uart_TX as 8N1 frames at a programmable bit period. Reports FIFO level and busy status, and raises a maskable level interrupt when transmission drains.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2
DIV_WIDTH, 16, width of the bit-period divisor

Ports:
clock  input  1  single clock for all logic
resetn  input  1  asynchronous active-low reset
wr_valid  input  1  byte push request from the register decode
wr_data  input  8  byte to transmit
wr_ready  output  1  FIFO can accept a byte
clk_div  input  DIV_WIDTH  bit period in clock cycles; 0 is treated as 1
irq_en  input  1  enables tx_irq
tx_level  output  log2(FIFO_DEPTH)+1  bytes currently held in the FIFO
tx_busy  output  1  serialiser is not in IDLE
tx_irq  output  1  drain interrupt (level)
uart_TX  output  1  serial line, idle high

Behaviour:
- Reset (asynchronous on resetn low, released synchronously to clock):
  - uart_TX=1, wr_ready=1, tx_level=0, tx_busy=0, tx_irq=0.
  - FIFO pointers, serialiser state and bit counter are cleared.
  - Reset mid-frame aborts the frame and drives the line high immediately. FIFO contents are lost.
- Push:
  - A byte is written when wr_valid && wr_ready at a rising clock edge.
  - wr_ready = (tx_level != FIFO_DEPTH), derived from the registered count.
  - A push while full is not accepted. No overflow and no data corruption.
- Pop:
  - The serialiser pops the FIFO head in the cycle it leaves IDLE or STOP to begin a new frame.
  - Simultaneous push and pop leaves tx_level unchanged and preserves both bytes in order.
  - Pointers wrap modulo FIFO_DEPTH. tx_level counts 0..FIFO_DEPTH.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: uart_TX=1. If FIFO is non-empty, pop, latch the byte into the shift register, latch clk_div (0 maps to 1) into the period register, go to START. tx_busy goes high in the next cycle.
  - START: uart_TX=0 for one bit period.
  - DATA: 8 bits, LSB first, each for one bit period. A 3-bit counter selects the bit; after bit 7, go to STOP.
  - STOP: uart_TX=1 for one bit period. At the end, if FIFO is non-empty, pop and go to START directly (back-to-back frames, no idle gap); otherwise go to IDLE.
- Bit timing:
  - The period counter counts from 0 to period-1, and the state or bit advances on terminal count.
  - A frame is exactly 10*period cycles.
  - The first START cycle appears on uart_TX one cycle after the FIFO write that made the FIFO non-empty while in IDLE.
  - clk_div changes take effect only at the next frame start. A frame in progress is unaffected.
- uart_TX is driven from a register (glitch-free).
- tx_irq is registered, = irq_en && (tx_level==0) && state==IDLE.
  - It asserts one cycle after the drain condition becomes true.
  - It deasserts one cycle after a push or after irq_en falls.

Test Plan:
- Reset then idle: resetn low for 3 cycles, then high for 20 cycles with no push -> uart_TX=1 and tx_busy=0 throughout; tx_irq=0 while irq_en=0.
- Single byte: clk_div=4, push 0xA5 -> uart_TX pattern 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). tx_irq rises one cycle after STOP ends with irq_en=1.
- Back-to-back: clk_div=2, push 0x00 then 0xFF in consecutive cycles -> two frames totalling 40 cycles with no idle cycle between the STOP of frame 1 and the START of frame 2; tx_level goes 1,1,0 as pops occur.
- Full FIFO: clk_div=100, push 18 bytes 0x00..0x11 with wr_valid held high -> 17 accepted (one popped immediately), wr_ready low once tx_level=16. Serial output is bytes 0x00..0x10 in order.
- Divisor edge: clk_div=0 -> 1-cycle bits, 10-cycle frame. Change clk_div 3->8 mid-frame -> current frame stays at 3 cycles/bit, next frame uses 8 cycles/bit.
- Reset mid-frame: assert resetn low during DATA bit 3 with 5 bytes queued -> uart_TX=1 asynchronously. After release, tx_level=0 and no further frames are sent.
